// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access size, FSM states, lane count.
package lsu_pkg;

  localparam int LSU_BYTE_LANES = 4;
  localparam int LSU_WORD_W     = 8 * LSU_BYTE_LANES;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RMW  = 2'd2
  } lsu_state_e;

  // Encoding 3 behaves as a full word access.
  function automatic mem_size_e decode_size(input logic [1:0] s);
    case (s)
      2'd0:    return BYTE;
      2'd1:    return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: load extract with sign/zero extension, and sub-word store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [LSU_WORD_W-1:0] rd_word_i,
  input  logic [LSU_WORD_W-1:0] wdata_i,
  input  logic [1:0]            offset_i,
  input  mem_size_e             size_i,
  input  logic                  uns_i,
  output logic [LSU_WORD_W-1:0] load_data_o,
  output logic [LSU_WORD_W-1:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = rd_word_i[{offset_i, 3'b000} +: 8];
    half_sel     = rd_word_i[{offset_i[1], 4'b0000} +: 16];
    load_data_o  = rd_word_i;
    merge_data_o = rd_word_i;
    case (size_i)
      BYTE: begin
        load_data_o = {{(LSU_WORD_W-8){~uns_i & byte_sel[7]}}, byte_sel};
        merge_data_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      // offset bit 0 is ignored, so a misaligned half is aligned down
      HALF: begin
        load_data_o = {{(LSU_WORD_W-16){~uns_i & half_sel[15]}}, half_sel};
        merge_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_o  = rd_word_i;
        merge_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide memory with a registered read address.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
//
//   state | meaning
//   IDLE  | accept request; word stores complete here
//   LOAD  | memory data valid, extract lane and complete the load
//   RMW   | old word valid, merge sub-word data and issue the write
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  done,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memDataIn,
  output logic                  memWe,
  input  logic [DATA_WIDTH-1:0] memDataOut
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  mem_size_e             size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  mem_size_e             size_in;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic                  misalign;
  logic                  word_store;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  assign size_in    = decode_size(size);
  assign addr_al    = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign word_store = wr && (size_in == WORD);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size_in == HALF) && addr[0]) ||
                    ((size_in == WORD) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_lane u_lane (
    .rd_word_i    (memDataOut),
    .wdata_i      (wdata_q),
    .offset_i     (off_q),
    .size_i       (size_q),
    .uns_i        (uns_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req && !misalign && !word_store) begin
          addr_d  = addr_al;
          off_d   = addr[1:0];
          size_d  = size_in;
          uns_d   = uns;
          wdata_d = wdata;
          state_d = wr ? RMW : LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs are forced quiet while reset is held, which also kills a pending RMW write.
  always_comb begin
    rdata     = '0;
    stall     = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    memAddr   = '0;
    memDataIn = '0;
    memWe     = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (misalign) begin
              fault = 1'b1;
              done  = 1'b1;
            end else if (word_store) begin
              memAddr   = addr_al;
              memDataIn = wdata;
              memWe     = 1'b1;
              done      = 1'b1;
            end else begin
              memAddr = addr_al;
              stall   = 1'b1;
            end
          end
        end
        LOAD: begin
          memAddr = addr_q;
          rdata   = load_data;
          done    = 1'b1;
        end
        RMW: begin
          memAddr   = addr_q;
          memDataIn = merge_data;
          memWe     = 1'b1;
          done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
